shift_sched: RTL and testbench
==============================

// Module: shift_sched
// PURPOSE
//   Two-requester scheduler for the shared 16-bit Shifter (operand a, 5-bit signed shiftAmt, registered result r).
//   Arbitrates round-robin between requester 0 (execute stage) and requester 1 (mul/div helper).
//   Accepts one operation at a time, drives the Shifter operands and waits out the Shifter latency.
//   Captures r and returns it to the owning requester with a one-cycle valid pulse.
// PARAMETERS
//   WIDTH      16  data width of a / r
//   AMT_W      5   shift-amount width; two's complement, passed to Shifter unmodified
//   SHIFT_LAT  1   Shifter latency in clk cycles (0 = combinational); legal 0..7
// PORTS
//   clk        in   1        rising-edge clock
//   reset      in   1        synchronous, active-high reset
//   req0_valid in   1        requester 0 has an operation
//   req0_a     in   WIDTH    requester 0 operand
//   req0_amt   in   AMT_W    requester 0 shift amount
//   req0_ready out  1        requester 0 accepted this cycle when req0_valid && req0_ready
//   req1_valid in   1        requester 1 has an operation
//   req1_a     in   WIDTH    requester 1 operand
//   req1_amt   in   AMT_W    requester 1 shift amount
//   req1_ready out  1        requester 1 handshake
//   rsp0_valid out  1        one-cycle pulse: rsp_r belongs to requester 0
//   rsp1_valid out  1        one-cycle pulse: rsp_r belongs to requester 1
//   rsp_r      out  WIDTH    captured Shifter result; held until next capture
//   sh_a       out  WIDTH    to Shifter .a
//   sh_amt     out  AMT_W    to Shifter .shiftAmt
//   sh_r       in   WIDTH    from Shifter .r
//   busy       out  1        high in any state other than IDLE
// BEHAVIOUR
//   Reset (sync, reset=1 at posedge): state=IDLE, all outputs 0, wait counter 0, last_grant=1 (req0 wins first tie).
//   All outputs registered. readyN combinational from state/arbiter; high only in IDLE, for the granted requester only.
//   Arbitration in IDLE:
//   - one valid -> grant it
//   - both valid -> grant the one != last_grant
//   - none -> both ready=0
//   - last_grant updates on handshake only.
//   FSM:
//   - IDLE  -> ISSUE on handshake: latch a/amt into sh_a/sh_amt, latch owner
//   - ISSUE -> WAIT when SHIFT_LAT>0, counter=SHIFT_LAT
//   - ISSUE -> RESP when SHIFT_LAT=0, capture sh_r
//   - WAIT  decrements the counter; in the cycle counter==1, capture sh_r and go to RESP
//   - RESP  -> IDLE, pulses rspN_valid for owner
//   Timing: handshake at cycle T; sh_a/sh_amt valid from T+1 until the next handshake (held through IDLE).
//   sh_r sampled at end of cycle T+1+SHIFT_LAT; rspN_valid=1 in cycle T+2+SHIFT_LAT; earliest next handshake T+3+SHIFT_LAT.
//   Exactly one rspN_valid per accepted op; never both rsp valids in one cycle; no rsp without a prior handshake.
//   shiftAmt=0 is not bypassed: same latency as any other op; result equals a.
//   Negative shiftAmt (e.g. 5'b11111) passed through unchanged; direction is the Shifter's contract.
//   Requests arriving while busy: ready=0, requester holds valid/operands; no drop, no reorder per requester.
//   valid deasserted before handshake: no effect, no grant recorded.
//   Reset mid-operation: op abandoned, no rsp pulse, state IDLE next cycle, last_grant=1.
//   Counter width 3 bits; SHIFT_LAT>7 is illegal (elaboration-time check).
// TESTING (SHIFT_LAT=1, bench instantiates real Shifter)
//   1 Reset then idle, no valids -> busy=0, readys=0, rsp valids=0, sh_a=0, sh_amt=0 for 10 cycles.
//   2 req0 a=128 amt=1 at T -> req0_ready=1 at T, sh_a=128 from T+1, rsp0_valid=1 at T+3 only, rsp_r=256.
//   3 req0 (a=100,amt=4) and req1 (a=10000,amt=3) both valid at T after reset
//     -> req0 granted first, rsp0 r=1600 at T+3.
//     -> req1 granted at T+4, rsp1 r=80000 mod 2^16=14464 at T+7.
//   4 Both valid continuously for 8 ops -> grants alternate 0,1,0,1..., one rsp per op, 4-cycle spacing.
//   5 req1 a=10000 amt=5'b11111 -> rsp_r equals Shifter output for (10000,-1), forwarded unchanged; amt=0 -> rsp_r=a.
//   6 reset asserted in WAIT -> no rsp pulse, busy=0 next cycle; pending req0 granted on the following cycle.

Source files
------------

// File: rtl/shift_sched_if.sv
// ---------------------------------------------------------------------------
// shift_sched_if
//   Bundle of every non-clock signal of the shift scheduler: the two
//   requester handshakes, the shared response and the Shifter operand/result
//   bus.
//   Modports:
//     slave  - the scheduler side (consumes requests and sh_r, drives the rest)
//     master - the requester/Shifter side (the mirror image)
// ---------------------------------------------------------------------------
interface shift_sched_if #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 5
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_a;
    logic [AMT_W-1:0] req0_amt;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_a;
    logic [AMT_W-1:0] req1_amt;
    logic             req1_ready;
    logic             rsp0_valid;
    logic             rsp1_valid;
    logic [WIDTH-1:0] rsp_r;
    logic [WIDTH-1:0] sh_a;
    logic [AMT_W-1:0] sh_amt;
    logic [WIDTH-1:0] sh_r;
    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_amt,
        input  req1_valid, req1_a, req1_amt,
        input  sh_r,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_r,
        output sh_a, sh_amt, busy
    );

    modport master (
        output req0_valid, req0_a, req0_amt,
        output req1_valid, req1_a, req1_amt,
        output sh_r,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_r,
        input  sh_a, sh_amt, busy
    );
endinterface

// File: rtl/shift_sched.sv
// ---------------------------------------------------------------------------
// shift_sched
//   Round-robin scheduler in front of a shared Shifter. Accepts one operation
//   at a time from requester 0 or 1, drives the Shifter operands, waits out
//   SHIFT_LAT cycles, captures the result and returns it to the owner with a
//   one-cycle valid pulse.
//   Ports:
//     clk   - rising-edge clock
//     reset - synchronous, active-high reset
//     bus   - shift_sched_if.slave: req0/req1 handshakes, rsp0/rsp1 pulses,
//             rsp_r, Shifter operands sh_a/sh_amt, Shifter result sh_r, busy
// ---------------------------------------------------------------------------
module shift_sched #(
    parameter int WIDTH     = 16,
    parameter int AMT_W     = 5,
    parameter int SHIFT_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    shift_sched_if.slave bus
);

    generate
        if (SHIFT_LAT < 0 || SHIFT_LAT > 7) begin : g_bad_lat
            $error("shift_sched: SHIFT_LAT must be in 0..7");
        end
    endgenerate

    localparam bit         ZERO_LAT = (SHIFT_LAT == 0);
    localparam logic [2:0] LAT3     = 3'(SHIFT_LAT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_LAT,
        RESP
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] cnt;
    logic       last_grant;   // requester that won the most recent handshake
    logic       owner;        // requester that owns the op in flight
    logic       idle;
    logic       grant0;
    logic       grant1;
    logic       hs0;
    logic       hs1;
    logic       capture;

    // Ready is suppressed during reset so nothing is accepted in a cycle whose
    // state update is about to be discarded.
    assign idle   = (state == IDLE) && !reset;
    assign grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
    assign grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);

    assign bus.req0_ready = idle && grant0;
    assign bus.req1_ready = idle && grant1;

    assign hs0 = bus.req0_ready;   // ready already implies valid
    assign hs1 = bus.req1_ready;

    // The Shifter result is valid at the end of the cycle SHIFT_LAT after ISSUE.
    assign capture = (state == ISSUE && ZERO_LAT) ||
                     (state == WAIT_LAT && cnt == 3'd1);

    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; otherwise a latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (hs0 || hs1) state_nxt = ISSUE;
            ISSUE:    state_nxt = ZERO_LAT ? RESP : WAIT_LAT;
            WAIT_LAT: if (cnt == 3'd1) state_nxt = RESP;
            RESP:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= 3'd0;
            last_grant     <= 1'b1;
            owner          <= 1'b0;
            bus.sh_a       <= '0;
            bus.sh_amt     <= '0;
            bus.rsp_r      <= '0;
            bus.rsp0_valid <= 1'b0;
            bus.rsp1_valid <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            state          <= state_nxt;
            bus.busy       <= (state_nxt != IDLE);
            bus.rsp0_valid <= capture && !owner;
            bus.rsp1_valid <= capture &&  owner;

            if (hs0 || hs1) begin
                owner      <= hs1;
                last_grant <= hs1;
                bus.sh_a   <= hs1 ? bus.req1_a   : bus.req0_a;
                bus.sh_amt <= hs1 ? bus.req1_amt : bus.req0_amt;
            end

            if (state == ISSUE)
                cnt <= LAT3;
            else if (state == WAIT_LAT)
                cnt <= cnt - 3'd1;

            if (capture)
                bus.rsp_r <= bus.sh_r;
        end
    end

endmodule

// File: tb/tb_shift_sched.sv
// ---------------------------------------------------------------------------
// tb_shift_sched
//   Directed bench for shift_sched with SHIFT_LAT=1 and a one-cycle registered
//   Shifter model (positive amount shifts left, negative shifts right).
//   Cycle convention: inputs are driven 1 time unit after a rising edge and
//   outputs are sampled 1 time unit later, well before the falling edge.
// ---------------------------------------------------------------------------
module tb_shift_sched;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    shift_sched_if #(.WIDTH(16), .AMT_W(5)) bus ();

    shift_sched #(.WIDTH(16), .AMT_W(5), .SHIFT_LAT(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] shifter(input logic [15:0] a, input logic [4:0] amt);
        logic signed [4:0] s;
        s = amt;
        if (s >= 0) return a << s;
        return a >> (-s);
    endfunction

    always_ff @(posedge clk) bus.sh_r <= shifter(bus.sh_a, bus.sh_amt);

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_amt = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_amt = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    // One isolated operation, checked cycle by cycle from handshake T to T+4.
    task automatic run_op(input bit who, input logic [15:0] a, input logic [4:0] amt,
                          input logic [15:0] exp_r, input string tag);
        logic [1:0] exp_rsp;
        exp_rsp = who ? 2'b10 : 2'b01;
        if (who) begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_amt = amt;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_amt = amt;
        end
        #1;
        n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== exp_rsp) begin n_bad++; $display("FAIL %s ready@T: got %b exp %b", tag, {bus.req1_ready, bus.req0_ready}, exp_rsp); end
        cyc();
        idle_inputs();
        #1;
        n_cmp++; if (bus.sh_a !== a) begin n_bad++; $display("FAIL %s sh_a@T+1: got %0d exp %0d", tag, bus.sh_a, a); end
        n_cmp++; if (bus.sh_amt !== amt) begin n_bad++; $display("FAIL %s sh_amt@T+1: got %b exp %b", tag, bus.sh_amt, amt); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL %s busy@T+1: got %b exp 1", tag, bus.busy); end
        cyc(); #1;
        n_cmp++; if ({bus.rsp1_valid, bus.rsp0_valid} !== 2'b00) begin n_bad++; $display("FAIL %s rsp@T+2: got %b exp 00", tag, {bus.rsp1_valid, bus.rsp0_valid}); end
        cyc(); #1;
        n_cmp++; if ({bus.rsp1_valid, bus.rsp0_valid} !== exp_rsp) begin n_bad++; $display("FAIL %s rsp@T+3: got %b exp %b", tag, {bus.rsp1_valid, bus.rsp0_valid}, exp_rsp); end
        n_cmp++; if (bus.rsp_r !== exp_r) begin n_bad++; $display("FAIL %s rsp_r@T+3: got %0d exp %0d", tag, bus.rsp_r, exp_r); end
        cyc(); #1;
        n_cmp++; if ({bus.rsp1_valid, bus.rsp0_valid, bus.busy} !== 3'b000) begin n_bad++; $display("FAIL %s rsp/busy@T+4: got %b exp 000", tag, {bus.rsp1_valid, bus.rsp0_valid, bus.busy}); end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            #1;
            n_cmp++; if ({bus.busy, bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid} !== 5'b0) begin n_bad++; $display("FAIL reset_ctl[%0d]: got %b exp 00000", i, {bus.busy, bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid}); end
            n_cmp++; if ({bus.sh_a, bus.sh_amt} !== 21'd0) begin n_bad++; $display("FAIL reset_sh[%0d]: got %0h exp 0", i, {bus.sh_a, bus.sh_amt}); end
            cyc();
        end
    endtask

    task automatic test_single();
        run_op(1'b0, 16'd128, 5'd1, 16'd256, "single_req0");
    endtask

    task automatic test_tie();
        do_reset();
        // cycle T: both valid, req0 wins the first tie
        bus.req0_valid = 1'b1; bus.req0_a = 16'd100;   bus.req0_amt = 5'd4;
        bus.req1_valid = 1'b1; bus.req1_a = 16'd10000; bus.req1_amt = 5'd3;
        #1;
        n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin n_bad++; $display("FAIL tie ready@T: got %b exp 01", {bus.req1_ready, bus.req0_ready}); end
        cyc(); bus.req0_valid = 1'b0; #1;
        n_cmp++; if (bus.req1_ready !== 1'b0) begin n_bad++; $display("FAIL tie req1_ready busy@T+1: got %b exp 0", bus.req1_ready); end
        cyc(); #1;
        cyc(); #1;
        n_cmp++; if ({bus.rsp1_valid, bus.rsp0_valid} !== 2'b01) begin n_bad++; $display("FAIL tie rsp@T+3: got %b exp 01", {bus.rsp1_valid, bus.rsp0_valid}); end
        n_cmp++; if (bus.rsp_r !== 16'd1600) begin n_bad++; $display("FAIL tie rsp_r@T+3: got %0d exp 1600", bus.rsp_r); end
        cyc(); #1;
        n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin n_bad++; $display("FAIL tie ready@T+4: got %b exp 10", {bus.req1_ready, bus.req0_ready}); end
        cyc(); bus.req1_valid = 1'b0; #1;
        n_cmp++; if (bus.sh_a !== 16'd10000) begin n_bad++; $display("FAIL tie sh_a@T+5: got %0d exp 10000", bus.sh_a); end
        cyc(); #1;
        n_cmp++; if ({bus.rsp1_valid, bus.rsp0_valid} !== 2'b00) begin n_bad++; $display("FAIL tie rsp@T+6: got %b exp 00", {bus.rsp1_valid, bus.rsp0_valid}); end
        cyc(); #1;
        n_cmp++; if ({bus.rsp1_valid, bus.rsp0_valid} !== 2'b10) begin n_bad++; $display("FAIL tie rsp@T+7: got %b exp 10", {bus.rsp1_valid, bus.rsp0_valid}); end
        n_cmp++; if (bus.rsp_r !== 16'd14464) begin n_bad++; $display("FAIL tie rsp_r@T+7: got %0d exp 14464", bus.rsp_r); end
        cyc();
    endtask

    // Both requesters hold valid for four ops each: req0 op j is (10*(j+1), 1),
    // req1 op j is (100*(j+1), 2). Grants alternate every 4 cycles from cycle 0.
    task automatic test_back_to_back();
        int n0;
        int n1;
        bit hs_c;
        bit rs_c;
        bit own;
        int j;
        logic [15:0] exp_r;
        do_reset();
        n0 = 0;
        n1 = 0;
        for (int c = 0; c < 36; c++) begin
            bus.req0_valid = (n0 < 4); bus.req0_a = 16'(10 * (n0 + 1));  bus.req0_amt = 5'd1;
            bus.req1_valid = (n1 < 4); bus.req1_a = 16'(100 * (n1 + 1)); bus.req1_amt = 5'd2;
            #1;
            hs_c = (c % 4 == 0) && (c < 32);
            own  = ((c / 4) % 2) == 1;
            n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== {hs_c && own, hs_c && !own}) begin n_bad++; $display("FAIL b2b ready c=%0d: got %b exp %b", c, {bus.req1_ready, bus.req0_ready}, {hs_c && own, hs_c && !own}); end
            rs_c = (c % 4 == 3) && (c < 32);
            n_cmp++; if ({bus.rsp1_valid, bus.rsp0_valid} !== {rs_c && own, rs_c && !own}) begin n_bad++; $display("FAIL b2b rsp c=%0d: got %b exp %b", c, {bus.rsp1_valid, bus.rsp0_valid}, {rs_c && own, rs_c && !own}); end
            if (rs_c) begin
                j = (c / 4) / 2;
                exp_r = own ? 16'(400 * (j + 1)) : 16'(20 * (j + 1));
                n_cmp++; if (bus.rsp_r !== exp_r) begin n_bad++; $display("FAIL b2b rsp_r c=%0d: got %0d exp %0d", c, bus.rsp_r, exp_r); end
            end
            if (bus.req0_ready) n0++;
            if (bus.req1_ready) n1++;
            cyc();
        end
        idle_inputs();
        n_cmp++; if ({n1[3:0], n0[3:0]} !== 8'h44) begin n_bad++; $display("FAIL b2b op count: got %0d/%0d exp 4/4", n0, n1); end
    endtask

    task automatic test_amt_edges();
        run_op(1'b1, 16'd10000, 5'b11111, 16'd5000, "neg_amt");
        run_op(1'b1, 16'h1234, 5'd0, 16'h1234, "zero_amt");
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        // cycle T: req0 op (3,2) accepted
        bus.req0_valid = 1'b1; bus.req0_a = 16'd3; bus.req0_amt = 5'd2;
        #1;
        n_cmp++; if (bus.req0_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid ready@T: got %b exp 1", bus.req0_ready); end
        // T+1: a second req0 op becomes pending
        cyc(); bus.req0_a = 16'd7; bus.req0_amt = 5'd1; #1;
        n_cmp++; if (bus.req0_ready !== 1'b0) begin n_bad++; $display("FAIL rst_mid ready@T+1: got %b exp 0", bus.req0_ready); end
        // T+2: in WAIT, reset asserted
        cyc(); reset = 1'b1; #1;
        n_cmp++; if ({bus.busy, bus.req0_ready} !== 2'b10) begin n_bad++; $display("FAIL rst_mid busy/ready@T+2: got %b exp 10", {bus.busy, bus.req0_ready}); end
        // T+3: abandoned, idle, pending op granted
        cyc(); reset = 1'b0; #1;
        n_cmp++; if ({bus.busy, bus.rsp1_valid, bus.rsp0_valid} !== 3'b000) begin n_bad++; $display("FAIL rst_mid busy/rsp@T+3: got %b exp 000", {bus.busy, bus.rsp1_valid, bus.rsp0_valid}); end
        n_cmp++; if (bus.sh_a !== 16'd0) begin n_bad++; $display("FAIL rst_mid sh_a@T+3: got %0d exp 0", bus.sh_a); end
        n_cmp++; if (bus.req0_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid regrant@T+3: got %b exp 1", bus.req0_ready); end
        cyc(); idle_inputs(); #1;
        n_cmp++; if ({bus.sh_a, bus.rsp0_valid} !== {16'd7, 1'b0}) begin n_bad++; $display("FAIL rst_mid sh_a/rsp@T+4: got %0d/%b exp 7/0", bus.sh_a, bus.rsp0_valid); end
        cyc(); #1;
        n_cmp++; if (bus.rsp0_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid rsp@T+5: got %b exp 0", bus.rsp0_valid); end
        cyc(); #1;
        n_cmp++; if ({bus.rsp1_valid, bus.rsp0_valid} !== 2'b01) begin n_bad++; $display("FAIL rst_mid rsp@T+6: got %b exp 01", {bus.rsp1_valid, bus.rsp0_valid}); end
        n_cmp++; if (bus.rsp_r !== 16'd14) begin n_bad++; $display("FAIL rst_mid rsp_r@T+6: got %0d exp 14", bus.rsp_r); end
        cyc();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_tie();
        test_back_to_back();
        test_amt_edges();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
